// File: rtl/cam_sensor_tx_pkg.sv
// Shared types and constants for the camera sensor emulator: FSM states,
// pattern select codes and the CRC-16-CCITT helper.
package cam_sensor_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFP
    } state_t;

    typedef enum logic [1:0] {
        PAT_HRAMP   = 2'd0,
        PAT_VRAMP   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_FRAME   = 2'd3
    } pattern_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // MSB-first CRC-16-CCITT over one byte
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/cam_tx_pattern_gen.sv
// Combinational test-pattern pixel function: (x, line, frame_cnt, sel) -> y.
module cam_tx_pattern_gen
    import cam_sensor_tx_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] line,
    input  logic [7:0] frame_cnt,
    input  pattern_t   sel,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (sel)
            PAT_HRAMP:   y = x;
            PAT_VRAMP:   y = line;
            PAT_CHECKER: y = (x[3] ^ line[3]) ? 8'hFF : 8'h00;
            PAT_FRAME:   y = frame_cnt + x;
            default:     y = 8'h00;
        endcase
    end

endmodule

// File: rtl/cam_sensor_tx.sv
// Camera sensor emulator: pclk/hsync/vsync + 8-bit Y test patterns.
// Optional CRC-16 of each frame's active pixels when CAM_SENSOR_TX_CRC_EN is defined.
module cam_sensor_tx
    import cam_sensor_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 160,
    parameter int H_BLANK     = 16,
    parameter int V_ACTIVE    = 120,
    parameter int VSYNC_LINES = 2,
    parameter int VBP_LINES   = 2,
    parameter int VFP_LINES   = 2,
    parameter int PCLK_DIV    = 2
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        cam_rst,
    input  logic        cam_enb,
    input  logic [1:0]  pattern_sel,
    output logic [7:0]  cam_y,
    output logic        cam_pclk,
    output logic        cam_hsync,
    output logic        cam_vsync,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
`ifdef CAM_SENSOR_TX_CRC_EN
    ,
    output logic [15:0] crc_o,
    output logic        crc_valid
`endif
);

    localparam logic [15:0] X_LAST     = 16'(H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] H_ACT_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] VS_LAST    = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VBP_LAST   = 16'(VBP_LINES - 1);
    localparam logic [15:0] VA_LAST    = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VFP_LAST   = 16'(VFP_LINES - 1);
    localparam logic [15:0] DIV_LAST   = 16'(PCLK_DIV - 1);

    state_t      state, nxt_state;
    logic [15:0] x, nxt_x, line, nxt_line, div;
    logic        pclk, fall, frame_end, enter_vsync;
    logic        nxt_hsync, nxt_vsync;
    logic [7:0]  pix, nxt_y;
    pattern_t    sel_q;

    // Every state/data change happens on the clk_i edge where pclk falls
    assign fall = (state != ST_IDLE) && pclk && (div == DIV_LAST);

    always_comb begin
        nxt_state   = state;
        nxt_x       = x;
        nxt_line    = line;
        frame_end   = 1'b0;
        enter_vsync = 1'b0;
        if (state == ST_IDLE) begin
            if (cam_enb) begin
                nxt_state   = ST_VSYNC;
                nxt_x       = '0;
                nxt_line    = '0;
                enter_vsync = 1'b1;
            end
        end else if (fall) begin
            nxt_x = x + 16'd1;
            if (state == ST_ACTIVE) begin
                if (x == H_ACT_LAST) nxt_state = ST_HBLANK;
            end else if (x == X_LAST) begin
                nxt_x    = '0;
                nxt_line = line + 16'd1;
                case (state)
                    ST_VSYNC: if (line == VS_LAST) begin
                        nxt_state = ST_VBP;
                        nxt_line  = '0;
                    end
                    ST_VBP: if (line == VBP_LAST) begin
                        nxt_state = ST_ACTIVE;
                        nxt_line  = '0;
                    end
                    ST_HBLANK: begin
                        if (line == VA_LAST) begin
                            nxt_state = ST_VFP;
                            nxt_line  = '0;
                        end else begin
                            nxt_state = ST_ACTIVE;
                        end
                    end
                    ST_VFP: if (line == VFP_LAST) begin
                        nxt_line  = '0;
                        frame_end = 1'b1;
                        if (cam_enb) begin
                            nxt_state   = ST_VSYNC;
                            enter_vsync = 1'b1;
                        end else begin
                            nxt_state = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    cam_tx_pattern_gen u_pattern (
        .x         (nxt_x[7:0]),
        .line      (nxt_line[7:0]),
        .frame_cnt (frame_cnt),
        .sel       (sel_q),
        .y         (pix)
    );

    assign nxt_hsync = (nxt_state == ST_ACTIVE);
    assign nxt_vsync = (nxt_state == ST_VSYNC);
    assign nxt_y     = nxt_hsync ? pix : 8'h00;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            x     <= '0;
            line  <= '0;
        end else if (cam_rst) begin
            state <= ST_IDLE;
            x     <= '0;
            line  <= '0;
        end else begin
            state <= nxt_state;
            x     <= nxt_x;
            line  <= nxt_line;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            div        <= '0;
            pclk       <= 1'b0;
            sel_q      <= PAT_HRAMP;
            cam_y      <= 8'h00;
            cam_hsync  <= 1'b0;
            cam_vsync  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
        end else if (cam_rst) begin
            div        <= '0;
            pclk       <= 1'b0;
            sel_q      <= PAT_HRAMP;
            cam_y      <= 8'h00;
            cam_hsync  <= 1'b0;
            cam_vsync  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
        end else begin
            // Divider idles at zero so the first fall is one full pclk period after leaving IDLE
            if (state == ST_IDLE) begin
                div  <= '0;
                pclk <= 1'b0;
            end else if (div == DIV_LAST) begin
                div  <= '0;
                pclk <= ~pclk;
            end else begin
                div <= div + 16'd1;
            end
            if (enter_vsync) sel_q <= pattern_t'(pattern_sel);
            cam_y      <= nxt_y;
            cam_hsync  <= nxt_hsync;
            cam_vsync  <= nxt_vsync;
            frame_done <= frame_end;
            frame_cnt  <= frame_cnt + 8'(frame_end);
        end
    end

    assign cam_pclk = pclk;

`ifdef CAM_SENSOR_TX_CRC_EN
    logic [15:0] crc_acc;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            crc_acc   <= CRC_INIT;
            crc_o     <= 16'h0000;
            crc_valid <= 1'b0;
        end else if (cam_rst) begin
            crc_acc   <= CRC_INIT;
            crc_o     <= 16'h0000;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= frame_end;
            if (frame_end) crc_o <= crc_acc;
            if (enter_vsync) begin
                crc_acc <= CRC_INIT;
            end else if (fall && nxt_hsync) begin
                crc_acc <= crc16_byte(crc_acc, nxt_y);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_sensor_tx.sv
// Self-checking bench for cam_sensor_tx: frame-timing model plus directed literal checks.
module tb_cam_sensor_tx;

    localparam int HA = 4, HB = 2, VA = 3, VS = 1, VBP = 1, VFP = 1, D = 2;
    localparam int LL = HA + HB;
    localparam int FRAME_CLK = LL * (VS + VBP + VA + VFP) * 2 * D;

    logic       clk_i = 1'b0;
    logic       reset_n = 1'b0;
    logic       cam_rst = 1'b0;
    logic       cam_enb = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic [7:0] cam_y, frame_cnt;
    logic       cam_pclk, cam_hsync, cam_vsync, frame_done;
`ifdef CAM_SENSOR_TX_CRC_EN
    logic [15:0] crc_o;
    logic        crc_valid;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    cam_sensor_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
        .VBP_LINES(VBP), .VFP_LINES(VFP), .PCLK_DIV(D)
    ) dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .cam_rst     (cam_rst),
        .cam_enb     (cam_enb),
        .pattern_sel (pattern_sel),
        .cam_y       (cam_y),
        .cam_pclk    (cam_pclk),
        .cam_hsync   (cam_hsync),
        .cam_vsync   (cam_vsync),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
`ifdef CAM_SENSOR_TX_CRC_EN
        ,
        .crc_o       (crc_o),
        .crc_valid   (crc_valid)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] model_pix(input int px, input int a, input int fc, input int sel);
        case (sel)
            0:       return 8'(px);
            1:       return 8'(a);
            2:       return (((px >> 3) & 1) != ((a >> 3) & 1)) ? 8'hFF : 8'h00;
            default: return 8'((fc + px) % 256);
        endcase
    endfunction

`ifdef CAM_SENSOR_TX_CRC_EN
    function automatic logic [15:0] frame_crc(input int fc, input int sel);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = 16'hFFFF;
        for (int a = 0; a < VA; a++) begin
            for (int px = 0; px < HA; px++) begin
                d = model_pix(px, a, fc, sel);
                for (int b = 7; b >= 0; b--) begin
                    fb = c[15] ^ d[b];
                    c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                end
            end
        end
        return c;
    endfunction
    logic [15:0] m_crc = 16'h0;
    logic        m_crcv = 1'b0;
`endif

    // Behavioural model: a running frame is just a clock count since leaving IDLE
    bit m_run = 0;
    int m_t = 0, m_fcnt = 0, m_sel = 0;
    bit m_fdone = 0;

    always @(posedge clk_i) begin
        int p, ph, ln, px, e_y;
        bit e_pclk, e_hs, e_vs;
        cyc = cyc + 1;
        m_fdone = 0;
`ifdef CAM_SENSOR_TX_CRC_EN
        m_crcv = 0;
`endif
        if (!reset_n || cam_rst) begin
            m_run = 0; m_t = 0; m_fcnt = 0; m_sel = 0;
`ifdef CAM_SENSOR_TX_CRC_EN
            m_crc = 16'h0;
`endif
        end else if (!m_run) begin
            if (cam_enb) begin
                m_run = 1; m_t = 0; m_sel = int'(pattern_sel);
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == FRAME_CLK) begin
                m_fdone = 1;
`ifdef CAM_SENSOR_TX_CRC_EN
                m_crc  = frame_crc(m_fcnt, m_sel);
                m_crcv = 1;
`endif
                m_fcnt = (m_fcnt + 1) % 256;
                if (cam_enb) begin
                    m_t = 0; m_sel = int'(pattern_sel);
                end else begin
                    m_run = 0;
                end
            end
        end
        e_pclk = 0; e_hs = 0; e_vs = 0; e_y = 0;
        if (m_run) begin
            p  = m_t / (2 * D);
            ph = m_t % (2 * D);
            ln = p / LL;
            px = p % LL;
            e_pclk = (ph >= D);
            e_vs   = (ln < VS);
            e_hs   = (ln >= VS + VBP) && (ln < VS + VBP + VA) && (px < HA);
            if (e_hs) e_y = int'(model_pix(px, ln - VS - VBP, m_fcnt, m_sel));
        end
        #1;
        check("pclk", int'(cam_pclk), int'(e_pclk));
        check("hsync", int'(cam_hsync), int'(e_hs));
        check("vsync", int'(cam_vsync), int'(e_vs));
        check("y", int'(cam_y), e_y);
        check("frame_done", int'(frame_done), int'(m_fdone));
        check("frame_cnt", int'(frame_cnt), m_fcnt);
`ifdef CAM_SENSOR_TX_CRC_EN
        check("crc_valid", int'(crc_valid), int'(m_crcv));
        check("crc_o", int'(crc_o), int'(m_crc));
`endif
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_hsync();
        bit seen = 0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (cam_hsync) begin
                seen = 1;
                break;
            end
        end
        check("hsync_timeout", int'(seen), 1);
    endtask

    task automatic check_line(input int base);
        for (int i = 0; i < LL; i++) begin
            check("line_hsync", int'(cam_hsync), (i < HA) ? 1 : 0);
            check("line_y", int'(cam_y), (i < HA) ? base + i : 0);
            repeat (2 * D) step();
        end
    endtask

    task automatic wait_fd(output int at);
        at = -1;
        for (int n = 0; n < 400; n++) begin
            step();
            if (frame_done) begin
                at = cyc;
                break;
            end
        end
        check("frame_done_timeout", int'(at >= 0), 1);
    endtask

    initial begin
        int t1, t2, t3, t4, pulses, highs;
        repeat (3) @(negedge clk_i);
        reset_n = 1'b1;

        pulses = 0; highs = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            highs  += int'(cam_pclk);
            pulses += int'(cam_vsync);
        end
        check("idle_pclk_highs", highs, 0);
        check("idle_vsync_highs", pulses, 0);

        @(negedge clk_i);
        cam_enb = 1'b1;
        pattern_sel = 2'd0;
        wait_hsync();
        check_line(0);
        @(negedge clk_i);
        pattern_sel = 2'd3;
        wait_fd(t1);
        check("frame_cnt_1", int'(frame_cnt), 1);
        wait_hsync();
        check_line(1);
        wait_fd(t2);
        check("frame_period_2", t2 - t1, 144);
        check("frame_cnt_2", int'(frame_cnt), 2);
        wait_fd(t3);
        check("frame_period_3", t3 - t2, 144);
        check("frame_cnt_3", int'(frame_cnt), 3);

        repeat (74) @(posedge clk_i);
        @(negedge clk_i);
        cam_enb = 1'b0;
        wait_fd(t4);
        check("last_frame_period", t4 - t3, 144);
        check("frame_cnt_4", int'(frame_cnt), 4);
        pulses = 0; highs = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            pulses += int'(frame_done);
            highs  += int'(cam_pclk);
        end
        check("no_extra_frame_done", pulses, 0);
        check("stopped_pclk_highs", highs, 0);

        @(negedge clk_i);
        cam_enb = 1'b1;
        repeat (60) @(posedge clk_i);
        @(negedge clk_i);
        cam_rst = 1'b1;
        step();
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_pclk", int'(cam_pclk), 0);
        @(negedge clk_i);
        cam_rst = 1'b0;
        step();
        check("restart_vsync", int'(cam_vsync), 1);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk_i);
            pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) cam_enb = ~cam_enb;
            cam_rst = ($urandom_range(0, 1499) == 0);
        end
        @(negedge clk_i);
        cam_rst = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
